// File: rtl/mcp_scan_ctrl_pkg.sv
// Shared definitions for the multi-channel ADC scan controller:
// FSM state encoding, default geometry and default alarm thresholds.
package mcp_scan_ctrl_pkg;

  localparam int NUM_CH_DEF   = 8;
  localparam int ADC_BITS_DEF = 10;

  localparam logic [9:0] THRESH_HI_DEF = 10'd600;
  localparam logic [9:0] THRESH_LO_DEF = 10'd560;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    SELECT    = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4,
    STORE     = 3'd5
  } state_t;

endpackage

// File: rtl/mcp_scan_ctrl_tick.sv
// Scan period generator: free-running 0..PERIOD_CYC-1 counter that only
// runs while enabled, with a tick asserted in the wrap cycle.
module scan_tick_gen
  import mcp_scan_ctrl_pkg::*;
#(
  parameter int PERIOD_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/mcp_scan_ctrl.sv
// Periodic ADC scan controller: walks the channel mask once per period,
// issues conversions to an SPI converter, publishes results and drives an alarm LED.
module mcp_scan_ctrl
  import mcp_scan_ctrl_pkg::*;
#(
  parameter int                  NUM_CH      = NUM_CH_DEF,
  parameter int                  ADC_BITS    = ADC_BITS_DEF,
  parameter int                  PERIOD_CYC  = 50000,
  parameter int                  TIMEOUT_CYC = 4096,
  parameter logic [ADC_BITS-1:0] THRESH_HI   = THRESH_HI_DEF,
  parameter logic [ADC_BITS-1:0] THRESH_LO   = THRESH_LO_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [2:0]          alarm_ch,
  output logic                conv_start,
  output logic [2:0]          conv_ch,
  input  logic                conv_busy,
  input  logic                conv_done,
  input  logic [ADC_BITS-1:0] conv_data,
  output logic                res_valid,
  output logic [2:0]          res_ch,
  output logic [ADC_BITS-1:0] res_data,
  output logic                scan_done,
  output logic                timeout_err,
  output logic                led,
  output state_t              dbg_state
);

  localparam int PTR_W  = $clog2(NUM_CH + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [TCNT_W-1:0] r_tcnt;

  logic w_tick;
  logic w_ptr_in_range;
  logic w_ptr_last;
  logic w_mask_bit;
  logic w_tmo;
  logic w_alarm_hit;

  scan_tick_gen #(
    .PERIOD_CYC (PERIOD_CYC)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (w_tick)
  );

  assign w_ptr_in_range = (r_ptr < PTR_W'(NUM_CH));
  assign w_ptr_last     = (r_ptr == PTR_W'(NUM_CH - 1));
  assign w_mask_bit     = w_ptr_in_range && ch_mask[r_ptr[CH_W-1:0]];
  assign w_tmo          = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));
  assign w_alarm_hit    = (conv_ch == alarm_ch);
  assign dbg_state      = r_state;

  // Converter handshake: conv_start is a single-cycle request issued only in a
  // cycle where conv_busy was sampled low; conv_done is honoured only in WAIT_DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_tcnt      <= '0;
      conv_start  <= 1'b0;
      conv_ch     <= '0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_data    <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
      led         <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      res_valid  <= 1'b0;
      scan_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ptr  <= '0;
          r_tcnt <= '0;
          if (enable) r_state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            r_ptr   <= '0;
            r_state <= SELECT;
          end
        end
        SELECT: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (!w_ptr_in_range) begin
            scan_done <= 1'b1;
            r_state   <= WAIT_TICK;
          end else if (w_mask_bit) begin
            conv_ch <= 3'(r_ptr);
            r_state <= START;
          end else if (w_ptr_last) begin
            scan_done <= 1'b1;
            r_state   <= WAIT_TICK;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        START: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (!conv_busy) begin
            conv_start <= 1'b1;
            r_tcnt     <= '0;
            r_state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A done arriving on the timeout cycle still wins.
          if (conv_done) begin
            res_valid <= 1'b1;
            res_ch    <= conv_ch;
            res_data  <= conv_data;
            if (w_alarm_hit) begin
              if (conv_data >= THRESH_HI) begin
                led <= 1'b1;
              end else if (conv_data <= THRESH_LO) begin
                led <= 1'b0;
              end
            end
            r_state <= STORE;
          end else if (w_tmo) begin
            timeout_err <= 1'b1;
            r_ptr       <= r_ptr + 1'b1;
            r_state     <= enable ? SELECT : IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        STORE: begin
          r_ptr   <= r_ptr + 1'b1;
          r_state <= enable ? SELECT : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mcp_scan_ctrl.md
MCP_SCAN_CTRL -- requirements
Module: mcp_scan_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_CH, 8, ADC input channels scanned.
- ADC_BITS, 10, conversion result width.
- PERIOD_CYC, 50000, clk cycles between scan starts.
- TIMEOUT_CYC, 4096, maximum clk cycles allowed for one conversion.
- THRESH_HI, 10'd600, alarm set level.
- THRESH_LO, 10'd560, alarm clear level.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- enable, in, 1, scanning permitted.
- ch_mask, in, NUM_CH, channels to include in the scan.
- alarm_ch, in, 3, channel monitored for the alarm.
- conv_start, out, 1, one-cycle request to the SPI converter.
- conv_ch, out, 3, channel for the request.
- conv_busy, in, 1, converter is mid-transaction.
- conv_done, in, 1, one-cycle pulse with a valid conv_data.
- conv_data, in, ADC_BITS, converted sample.
- res_valid, out, 1, one-cycle pulse: new result.
- res_ch, out, 3, channel of the result.
- res_data, out, ADC_BITS, result sample.
- scan_done, out, 1, one-cycle pulse after the last masked channel.
- timeout_err, out, 1, sticky conversion-timeout flag.
- led, out, 1, alarm indicator.

Function
REQ-003 The FSM SHALL have the states IDLE, WAIT_TICK, SELECT, START, WAIT_DONE and STORE.
REQ-004 The period counter SHALL count from 0 to PERIOD_CYC-1 and wrap. It SHALL pulse a tick on wrap. It SHALL free-run only while enable=1 and SHALL hold 0 otherwise.
REQ-005 State transitions SHALL be:
- IDLE -> WAIT_TICK when enable=1.
- WAIT_TICK -> SELECT on tick, with the scan pointer set to 0.
REQ-006 SELECT SHALL take one cycle per channel index. It SHALL advance the pointer past clear ch_mask bits.
- First set bit found -> START.
- Pointer passes NUM_CH-1 -> pulse scan_done, then go to WAIT_TICK.
- ch_mask=0 -> scan_done still pulses once per tick.
REQ-007 START SHALL wait while conv_busy=1. When conv_busy=0 it SHALL drive conv_start=1 and conv_ch=pointer for exactly one cycle, then go to WAIT_DONE.
REQ-008 conv_ch SHALL hold stable from START until the exit from WAIT_DONE.
REQ-009 WAIT_DONE SHALL go to STORE on conv_done. It SHALL capture conv_data in the same cycle.
REQ-010 In WAIT_DONE, if the timeout counter reaches TIMEOUT_CYC-1 without conv_done:
- set timeout_err;
- emit no result;
- increment the pointer and go to SELECT.
REQ-011 STORE SHALL pulse res_valid one cycle later than conv_done, with res_ch and res_data. It SHALL increment the pointer and go to SELECT.
REQ-012 res_ch and res_data SHALL hold their values until the next res_valid.
REQ-013 Alarm SHALL apply only on a STORE where res_ch==alarm_ch:
- set led when res_data >= THRESH_HI;
- clear led when res_data <= THRESH_LO;
- otherwise hold led.
REQ-014 Alarm comparisons SHALL be unsigned at ADC_BITS width.
REQ-015 enable falling mid-scan SHALL let the current conversion complete, or time out, before the FSM goes to IDLE. It SHALL NOT pulse scan_done.
REQ-016 A conv_done received outside WAIT_DONE SHALL be ignored.
REQ-017 conv_done and a timeout in the same cycle SHALL resolve to conv_done.
REQ-018 ch_mask SHALL be sampled in SELECT each cycle. Mid-scan changes SHALL affect only channels not yet visited.
REQ-019 timeout_err SHALL clear only on reset.

Reset
REQ-020 While rst_n=0 at a clk edge, the block SHALL force:
- FSM state = IDLE; all counters and the pointer = 0;
- conv_start = 0, conv_ch = 0;
- res_valid = 0, res_ch = 0, res_data = 0;
- scan_done = 0, timeout_err = 0, led = 0.
REQ-021 Reset mid-conversion SHALL abandon the conversion. The first conv_start after reset SHALL come no earlier than one full PERIOD_CYC.

Structure
REQ-022 A shared package SHALL hold:
- the FSM state enumeration;
- ADC_BITS, NUM_CH and the default thresholds.
REQ-023 The period counter SHALL be a sub-module, scan_tick_gen, with ports clk, rst_n, enable and tick.
REQ-024 The FSM, timeout counter and alarm logic SHALL stay in mcp_scan_ctrl.

Verification
REQ-025 The bench SHALL cover these directed scenarios (stimulus -> required response):
- PERIOD_CYC=100, ch_mask=8'b0000_0101, converter returns done 20 cycles after start with data=ch*100 -> conv_start for ch0 then ch2 only; res_valid with (0,0) then (2,200); one scan_done; repeats every 100 cycles.
- alarm_ch=2, ch2 samples 590, 600, 580, 560, 559 -> led 0, 1, 1, 0, 0.
- conv_done never asserted for ch0 with TIMEOUT_CYC=50 -> timeout_err=1 after 50 cycles; no res_valid for ch0; ch2 still converted.
- conv_busy held 1 for 30 cycles at START -> conv_start delayed until busy=0; exactly one pulse.
- rst_n=0 during WAIT_DONE, then stray conv_done -> all outputs at reset values; no res_valid; next conv_start ≥100 cycles after release.
- ch_mask=0 with enable=1 -> no conv_start; scan_done once per period.
